// File: rtl/des_pkg.sv
// DES key-schedule helpers shared by the sequential key scheduler.
// Contents: half-key and FSM state types, default per-round shift mask,
// PC-1 / PC-2 index tables (1-based, bit 1 = MSB, as in FIPS 46),
// and the pc1 / pc2 / rotl28 / rotr28 helper functions.
package des_pkg;

    typedef logic [27:0] half_key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    // Bit r set: round r rotates by one position, otherwise by two.
    localparam logic [15:0] SHIFT_MASK_DEFAULT = 16'h8103;

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Parity bits (LSB of each byte) are never referenced by PC-1.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
        return r;
    endfunction

    // amt is 1 or 2; any value other than 2 rotates by one.
    function automatic half_key_t rotl28(input half_key_t x, input logic [1:0] amt);
        return (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic half_key_t rotr28(input half_key_t x, input logic [1:0] amt);
        return (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

endpackage

// File: rtl/key_rotate_unit.sv
// Rotates both 28-bit halves of a {C,D} pair by 1 or 2 positions.
// Ports: cd (56, in), rotate_right (in, 0 = left), by_two (in, 0 = by one),
//        cd_rot (56, out). Purely combinational.
module key_rotate_unit
    import des_pkg::*;
(
    input  logic [55:0] cd,
    input  logic        rotate_right,
    input  logic        by_two,
    output logic [55:0] cd_rot
);
    logic [1:0] amt;
    half_key_t  c_half;
    half_key_t  d_half;

    assign amt    = by_two ? 2'd2 : 2'd1;
    assign c_half = cd[55:28];
    assign d_half = cd[27:0];

    always_comb begin
        if (rotate_right) cd_rot = {rotr28(c_half, amt), rotr28(d_half, amt)};
        else              cd_rot = {rotl28(c_half, amt), rotl28(d_half, amt)};
    end
endmodule

// File: rtl/permuted_choice_1.sv
// PC-1: 64-bit DES key -> 56-bit {C,D}. Pure wiring.
// Ports: key (64, in), key_pc1 (56, out).
module permuted_choice_1
    import des_pkg::*;
(
    input  logic [63:0] key,
    output logic [55:0] key_pc1
);
    assign key_pc1 = pc1(key);
endmodule

// File: rtl/permuted_choice_2.sv
// PC-2: 56-bit {C,D} -> 48-bit round subkey. Pure wiring.
// Ports: cd (56, in), subkey (48, out).
module permuted_choice_2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);
    assign subkey = pc2(cd);
endmodule

// File: rtl/des_key_sched_seq.sv
// Sequential DES key scheduler: a bank of KEY_SLOTS PC-1-reduced keys and a
// working C/D register that yields one PC-2 subkey per accepted handshake,
// forward (K0..K15) for encrypt or reverse (K15..K0) for decrypt.
// Ports:
//   clk, rst                 clock, async active-high reset
//   key_wr/key_wr_slot/key   key bank write (PC-1 applied on the way in)
//   start_valid/start_ready  run request handshake (start_slot, start_decrypt)
//   subkey_valid/ready       subkey stream; subkey, subkey_round, subkey_last
//   busy                     high while a run is in progress
module des_key_sched_seq
    import des_pkg::*;
#(
    parameter int          KEY_SLOTS  = 3,
    parameter logic [15:0] SHIFT_MASK = SHIFT_MASK_DEFAULT,
    parameter int          SLOT_W     = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic [SLOT_W-1:0] key_wr_slot,
    input  logic [63:0]       key,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [SLOT_W-1:0] start_slot,
    input  logic              start_decrypt,
    output logic              subkey_valid,
    input  logic              subkey_ready,
    output logic [47:0]       subkey,
    output logic [3:0]        subkey_round,
    output logic              subkey_last,
    output logic              busy
);
    sched_state_t state, state_nxt;

    logic [55:0] bank [KEY_SLOTS];
    logic [55:0] key_pc1;
    logic [55:0] bank_rd;
    logic [55:0] cd;
    logic [55:0] rot_in;
    logic [55:0] rot_out;
    logic [3:0]  round;
    logic [3:0]  shift_idx;
    logic        dec;
    logic        last;
    logic        start_fire;
    logic        sub_fire;

    permuted_choice_1 u_pc1 (.key(key), .key_pc1(key_pc1));
    permuted_choice_2 u_pc2 (.cd(cd), .subkey(subkey));

    // Out-of-range slot indices fall through to slot 0.
    always_comb begin
        bank_rd = bank[0];
        for (int i = 1; i < KEY_SLOTS; i++)
            if (start_slot == SLOT_W'(i)) bank_rd = bank[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KEY_SLOTS; i++) bank[i] <= '0;
        end else if (key_wr) begin
            for (int i = 0; i < KEY_SLOTS; i++)
                if (key_wr_slot == SLOT_W'(i)) bank[i] <= key_pc1;
        end
    end

    // One rotator serves both the encrypt pre-rotation at start (from the
    // bank, by s[0]) and the per-round step during a run (from C/D).
    // Encrypt steps to round+1 by s[round+1]; decrypt undoes s[round].
    assign rot_in    = (state == ST_IDLE) ? bank_rd : cd;
    assign shift_idx = (state == ST_IDLE) ? 4'd0 : (dec ? round : round + 4'd1);

    key_rotate_unit u_rot (
        .cd           (rot_in),
        .rotate_right (state == ST_RUN && dec),
        .by_two       (~SHIFT_MASK[shift_idx]),
        .cd_rot       (rot_out)
    );

    assign last = (state == ST_RUN) && (dec ? (round == 4'd0) : (round == 4'd15));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_ready  = 1'b0;
        subkey_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                subkey_valid = 1'b1;
                busy         = 1'b1;
                if (subkey_ready && last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign start_fire = start_valid && start_ready;
    assign sub_fire   = subkey_valid && subkey_ready;

    // Decrypt loads C0/D0 unrotated: the rotations sum to 28, so C16 = C0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd    <= '0;
            round <= '0;
            dec   <= 1'b0;
        end else if (start_fire) begin
            dec   <= start_decrypt;
            round <= start_decrypt ? 4'd15 : 4'd0;
            cd    <= start_decrypt ? bank_rd : rot_out;
        end else if (sub_fire && !last) begin
            cd    <= rot_out;
            round <= dec ? round - 4'd1 : round + 4'd1;
        end
    end

    assign subkey_round = round;
    assign subkey_last  = last;

endmodule

// File: doc/des_key_sched_seq.md
# des_key_sched_seq

Sequential, parametrised DES key scheduler. It stores up to KEY_SLOTS keys (already reduced by PC-1) and produces the 16 round subkeys one per cycle over a valid/ready stream. Subkeys come out in forward order for encryption or reverse order for decryption. It replaces the fully unrolled 16-subkey combinational scheduler and feeds an iterative round core or a 3DES sequencer (one slot per key).

## Interface
- KEY_SLOTS, default 3: number of stored keys, 1..4.
- SHIFT_MASK, default 16'h8103: bit r = 1 means round r rotates by 1, otherwise by 2. The sum of rotations must be 28.
- SLOT_W, default max(1, $clog2(KEY_SLOTS)): slot index width (derived).

Ports (clock and reset first):
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- key_wr  in  1  write key into slot key_wr_slot.
- key_wr_slot  in  SLOT_W  target slot.
- key  in  64  DES key; parity bits (LSB of each byte) are ignored.
- start_valid  in  1  request a schedule run.
- start_ready  out  1  high only in IDLE.
- start_slot  in  SLOT_W  key slot to expand.
- start_decrypt  in  1  0 = order K0..K15, 1 = order K15..K0.
- subkey_valid  out  1  subkey is valid.
- subkey_ready  in  1  consumer accepts the subkey.
- subkey  out  48  PC-2 of the current C/D pair.
- subkey_round  out  4  index of the subkey being presented (0..15).
- subkey_last  out  1  marks the final subkey of the run.
- busy  out  1  high in RUN.

## Operation
- **Slot bank**
  - KEY_SLOTS × 56-bit registers holding PC-1(key).
  - key_wr writes the bank at the clock edge.
  - The bank is independent of the FSM; writes are legal in any state.
- **FSM states:** IDLE, RUN.
- **IDLE → RUN** on start_valid & start_ready. The working C/D (2×28) is loaded from the bank slot:
  - Encrypt: load rotl(C,s[0]), rotl(D,s[0]); round = 0.
  - Decrypt: load C, D unrotated (the total rotation is 28, so C16 = C0); round = 15.
- **RUN:** subkey_valid = 1, subkey = PC-2({C,D}).
  - The output holds stable until subkey_valid & subkey_ready.
  - On each accepted subkey, encrypt: round+1, then rotl by s[round+1].
  - On each accepted subkey, decrypt: rotr by s[round], then round−1.
- **subkey_last** = (encrypt & round==15) | (decrypt & round==0).
  - Accepting the last subkey returns the FSM to IDLE.
  - C/D keep their value; subkey_valid drops.
- **Out-of-range start_slot** (≥ KEY_SLOTS) selects slot 0.
- **Simultaneous key_wr and start to the same slot:** the run uses the value stored before the edge; the new key applies to later runs.
- **key_wr to the slot being expanded mid-run:** no effect on the run, because C/D is a private copy.
- **start_valid while not IDLE:** not accepted; the requester holds it.
- **rst at any time:** IDLE immediately, run abandoned, bank, C/D and round cleared to 0.

## Timing
- **Reset values:** start_ready=1 (after rst deasserts), subkey_valid=0, subkey=PC-2(0)=0, subkey_round=0, subkey_last=0, busy=0.
- **Start latency:** start accepted at edge T, first subkey valid from T+1.
- **No backpressure:** subkeys on cycles T+1..T+16; IDLE and start_ready=1 at T+17. That is 17 cycles per run, with one bubble between back-to-back runs.
- **Write visibility:** key_wr at edge T is visible to a start accepted at edge T+1 or later.
- **Output path:** subkey is PC-2 wiring of registered C/D, with no logic levels beyond the permutation. subkey_round and subkey_last are registered or decoded from registers.

## Structure
- **Package des_pkg:**
  - PC1 and PC2 index tables.
  - SHIFT_MASK default constant.
  - Functions pc1(64→56), pc2(56→48), rotl28/rotr28(x, amt∈{1,2}).
  - Typedef for a 28-bit half key.
- **Reused modules:** permuted_choice_1 and permuted_choice_2 are instantiated for the permutations.
- **New sub-module key_rotate_unit:**
  - Inputs: {C,D}, direction, 1-or-2 select.
  - Output: the rotated {C,D}.
  - Purely combinational.

## Test plan
- **Encrypt run:** key 0x133457799BBCDFF1 in slot 0, encrypt start, subkey_ready=1 → 16 subkeys on T+1..T+16. Round 0 = 0x1B02EFFC7072, round 15 = 0xCB3D8B0E17F5, subkey_last only on round 15, start_ready=1 at T+17.
- **Decrypt run:** same key, decrypt → first subkey 0xCB3D8B0E17F5 with round=15, last subkey 0x1B02EFFC7072 with round=0. The full sequence equals the encrypt sequence reversed.
- **Backpressure:** random subkey_ready toggling → subkey and subkey_round held stable while valid & !ready. No subkey dropped or duplicated; all 16 match the reference model.
- **Same-edge write and start:** slot 1 holds key A; key_wr of key B to slot 1 in the same cycle as start(slot 1) → the run yields A's subkeys, and the next run yields B's.
- **Reset mid-run:** assert rst at round 7 → subkey_valid=0, busy=0, start_ready=1 after release, bank cleared. A start on slot 0 then yields PC-2 of zero, i.e. 0 for all rounds.
- **Slot range:** with KEY_SLOTS=3, start_slot=3 → uses slot 0. A start_valid held during RUN is not accepted until IDLE.
